veririsc_ctrl: RTL and testbench

Eight-phase instruction sequencer for the VeriRISC core. Each instruction takes eight clock cycles; every cycle the block decodes its internal phase counter together with the instruction-register opcode (`ex_type_pkg` encoding) and the ALU `zero` flag. From these it drives the memory, PC, IR and accumulator strobes, which sequence the ALU datapath through fetch, operand fetch, execute and store. It also detects `HLT` and freezes the machine until reset.

---
 rtl/veririsc_ctrl_if.sv | 52 +++++
 rtl/veririsc_ctrl.sv | 111 +++++++++++
 tb/tb_veririsc_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/veririsc_ctrl_if.sv
// Opcode package and the controller-to-datapath strobe bundle for VeriRISC.
// The step line exists only when VERIRISC_CTRL_STEP_EN is defined.
package ex_type_pkg;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

interface veririsc_ctrl_if;
    import ex_type_pkg::*;

    opcode_t    opcode;
    logic       zero;
`ifdef VERIRISC_CTRL_STEP_EN
    logic       step;
`endif
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       halt;
    logic       ld_pc;
    logic       data_e;
    logic       ld_ac;
    logic       wr;
    logic [2:0] phase;

    // Controller side
    modport slave (
`ifdef VERIRISC_CTRL_STEP_EN
        input  step,
`endif
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase
    );

    // Datapath side
    modport master (
`ifdef VERIRISC_CTRL_STEP_EN
        output step,
`endif
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, phase
    );
endinterface

// File: rtl/veririsc_ctrl.sv
// Eight-phase VeriRISC instruction sequencer with HLT freeze.
// Define VERIRISC_CTRL_STEP_EN to gate the phase 0 -> 1 transition on bus.step.
module veririsc_ctrl (
    input  logic               clk,
    input  logic               rst_,
    veririsc_ctrl_if.slave     bus
);
    import ex_type_pkg::*;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t phase_reg;
    phase_t phase_next;
    logic   halted_reg;
    logic   halted_next;
    logic   advance;
    logic   alu_op;

    assign alu_op = (bus.opcode inside {ADD, AND, XOR, LDA});

`ifdef VERIRISC_CTRL_STEP_EN
    assign advance = (phase_reg != INST_ADDR) || bus.step;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        phase_next  = phase_reg;
        halted_next = halted_reg;
        if (!halted_reg) begin
            // HLT parks the machine in OP_ADDR rather than advancing
            if (phase_reg == OP_ADDR && bus.opcode == HLT) begin
                halted_next = 1'b1;
            end else if (advance) begin
                phase_next = phase_t'(phase_reg + 3'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_reg  <= INST_ADDR;
            halted_reg <= 1'b0;
        end else begin
            phase_reg  <= phase_next;
            halted_reg <= halted_next;
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.halt   = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.data_e = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        if (halted_reg) begin
            bus.halt = 1'b1;
        end else begin
            case (phase_reg)
                INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = (bus.opcode == HLT);
                end
                OP_FETCH: begin
                    bus.rd = alu_op;
                end
                ALU_OP: begin
                    bus.rd     = alu_op;
                    bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
                    bus.ld_pc  = (bus.opcode == JMP);
                    bus.data_e = (bus.opcode == STO);
                end
                STORE: begin
                    bus.rd     = alu_op;
                    bus.ld_ac  = alu_op;
                    bus.ld_pc  = (bus.opcode == JMP);
                    bus.wr     = (bus.opcode == STO);
                    bus.data_e = (bus.opcode == STO);
                end
                default: ;
            endcase
        end
    end

    assign bus.phase = phase_reg;
endmodule

// File: tb/tb_veririsc_ctrl.sv
// Scoreboard bench for veririsc_ctrl: randomized opcodes/zero against a phase-table model.
module tb_veririsc_ctrl;
    import ex_type_pkg::*;

    logic clk = 1'b0;
    logic rst_ = 1'b0;

    veririsc_ctrl_if bus ();

    veririsc_ctrl dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [12:0] exp_q[$];
    int          m_phase;
    bit          m_halted;
    logic [2:0]  cur_op;
    bit          cur_step;

    // Vector layout: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr phase[2:0]
    function automatic logic [12:0] expect_vec(int ph, bit hl, logic [2:0] op, bit z);
        bit alu, sto, jmp;
        bit sel, rd, ld_ir, inc, hlt, ld_pc, data_e, ld_ac, wr;
        logic [2:0] ph3;
        if (hl) return {4'b0000, 1'b1, 4'b0000, 3'd4};
        alu    = (op >= 3'd2 && op <= 3'd5);
        sto    = (op == 3'd6);
        jmp    = (op == 3'd7);
        sel    = (ph <= 3);
        rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        ld_ir  = (ph == 2 || ph == 3);
        inc    = (ph == 4) || (ph == 6 && op == 3'd1 && z);
        hlt    = (ph == 4 && op == 3'd0);
        ld_pc  = (ph >= 6 && jmp);
        data_e = (ph >= 6 && sto);
        ld_ac  = (ph == 7 && alu);
        wr     = (ph == 7 && sto);
        ph3    = 3'(ph);
        return {sel, rd, ld_ir, inc, hlt, ld_pc, data_e, ld_ac, wr, ph3};
    endfunction

    function automatic logic [12:0] actual_vec();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
                bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr, bus.phase};
    endfunction

    // One clock: model the edge with the inputs of the cycle just ended, then drive new inputs
    task automatic cycle(input logic [2:0] op, input bit z, input bit stp);
        @(posedge clk);
        if (!m_halted) begin
            if (m_phase == 4 && cur_op == 3'd0) m_halted = 1'b1;
            else if (m_phase != 0 || cur_step) m_phase = (m_phase + 1) % 8;
        end
        #1;
        bus.opcode = opcode_t'(op);
        bus.zero   = z;
        cur_op     = op;
`ifdef VERIRISC_CTRL_STEP_EN
        bus.step   = stp;
        cur_step   = stp;
`else
        cur_step   = 1'b1;
        if (stp) ;
`endif
        exp_q.push_back(expect_vec(m_phase, m_halted, op, z));
    endtask

    task automatic async_reset(input string tag);
        logic [12:0] a;
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        a = actual_vec();
        checks++;
        if (a !== {1'b1, 8'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_%s got=%b exp=%b", tag, a, {1'b1, 8'b0, 3'd0});
        end else begin
            $display("reset_%s immediate outputs=%b", tag, a);
        end
        m_phase  = 0;
        m_halted = 1'b0;
`ifdef VERIRISC_CTRL_STEP_EN
        bus.step = 1'b0;
        cur_step = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    // Monitor: pop and compare once per cycle, mid-phase
    initial begin
        logic [12:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual_vec();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL strobes t=%0t got=%b exp=%b", $time, a, e);
                end else begin
                    $display("chk %0d phase=%0d strobes=%b", checks, a[2:0], a[12:3]);
                end
            end
        end
    end

    initial begin
        logic [2:0] op;
        logic [2:0] dir_ops[8];
        bit         dir_z[8];
        int         n;
        dir_ops = '{3'd2, 3'd1, 3'd1, 3'd6, 3'd7, 3'd3, 3'd4, 3'd5};
        dir_z   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        bus.opcode = ADD;
        bus.zero   = 1'b0;
        cur_op     = 3'd2;
        cur_step   = 1'b1;
`ifdef VERIRISC_CTRL_STEP_EN
        bus.step   = 1'b1;
`endif
        m_phase  = 0;
        m_halted = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;

        // Directed instructions, each opcode held for a full 8-phase sweep
        for (int i = 0; i < 8; i++) begin
            repeat (8) cycle(dir_ops[i], dir_z[i], 1'b1);
        end

        // Random non-HLT instructions with random zero per cycle
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(7, 1));
            repeat (8) cycle(op, 1'($urandom_range(1, 0)), 1'b1);
        end

        // Reset asserted in phase 5
        n = 0;
        while (m_phase != 5 && n < 16) begin
            cycle(3'd2, 1'b0, 1'b1);
            n++;
        end
        if (m_phase != 5) begin
            errors++;
            checks++;
            $display("FAIL reach_phase5 got=%0d exp=5", m_phase);
        end
        async_reset("phase5");
        repeat (16) cycle(3'($urandom_range(7, 1)), 1'($urandom_range(1, 0)), 1'b1);

        // HLT then random opcodes while frozen
        n = 0;
        while (!m_halted && n < 16) begin
            cycle(3'd0, 1'b0, 1'b1);
            n++;
        end
        if (!m_halted) begin
            errors++;
            checks++;
            $display("FAIL reach_halt got=0 exp=1");
        end
        repeat (25) cycle(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        async_reset("halted");
        repeat (16) cycle(3'd2, 1'b0, 1'b1);

`ifdef VERIRISC_CTRL_STEP_EN
        async_reset("step");
        repeat (10) cycle(3'd2, 1'b0, 1'b0);
        cycle(3'd2, 1'b0, 1'b1);
        repeat (12) cycle(3'd2, 1'b0, 1'b0);
        repeat (100) cycle(3'($urandom_range(7, 1)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
`endif

        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
